// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: grants one SDRAM burst at a time to one of NUM_WR
// write ports or NUM_RD read ports. Writes beat reads. The per-port burst
// address advances on completion and wraps to the start address at the top.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin order within each
// class. Without it, the lowest index wins.
module sdram_port_arbiter #(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int ASIZE  = 23,
  parameter int LSIZE  = 9
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_WR-1:0]       WR_LOAD,
  input  logic [NUM_WR*ASIZE-1:0] WR_ADDR,
  input  logic [NUM_WR*ASIZE-1:0] WR_MAX_ADDR,
  input  logic [NUM_WR*LSIZE-1:0] WR_LENGTH,
  input  logic [NUM_WR*LSIZE-1:0] WR_RUSEDW,
  input  logic [NUM_RD-1:0]       RD_LOAD,
  input  logic [NUM_RD*ASIZE-1:0] RD_ADDR,
  input  logic [NUM_RD*ASIZE-1:0] RD_MAX_ADDR,
  input  logic [NUM_RD*LSIZE-1:0] RD_LENGTH,
  input  logic [NUM_RD*LSIZE-1:0] RD_WUSEDW,
  input  logic                    CTRL_IDLE,
  input  logic                    mWR_DONE,
  input  logic                    mRD_DONE,
  output logic                    mWR,
  output logic                    mRD,
  output logic [ASIZE-1:0]        mADDR,
  output logic [LSIZE-1:0]        mLENGTH,
  output logic [NUM_WR-1:0]       WR_MASK,
  output logic [NUM_RD-1:0]       RD_MASK
);

  localparam int WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic               init_q;
  logic               mwr_q, mrd_q;
  logic [ASIZE-1:0]   maddr_q;
  logic [LSIZE-1:0]   mlen_q;
  logic [NUM_WR-1:0]  wr_mask_q;
  logic [NUM_RD-1:0]  rd_mask_q;

  logic [ASIZE-1:0]   wr_addr_w [NUM_WR];
  logic [LSIZE-1:0]   wr_len_w  [NUM_WR];
  logic [ASIZE-1:0]   rd_addr_w [NUM_RD];
  logic [LSIZE-1:0]   rd_len_w  [NUM_RD];
  logic [NUM_WR-1:0]  wr_cand;
  logic [NUM_RD-1:0]  rd_cand;
  logic               wr_any, rd_any, grant_wr, grant_rd, done_fire;
  logic [WPW-1:0]     wr_sel;
  logic [RPW-1:0]     rd_sel;

  // Next burst address: advance while a whole burst still fits below max,
  // otherwise wrap to the port's live start-address input. The comparison
  // uses one extra bit so that max-len cannot underflow.
  function automatic logic [ASIZE-1:0] next_addr(input logic [ASIZE-1:0] addr,
                                                 input logic [ASIZE-1:0] max,
                                                 input logic [LSIZE-1:0] len,
                                                 input logic [ASIZE-1:0] start);
    logic [ASIZE:0] len_x;
    logic [ASIZE:0] max_x;
    len_x = {{(ASIZE+1-LSIZE){1'b0}}, len};
    max_x = {1'b0, max};
    if (len_x > max_x)                    next_addr = start;
    else if ({1'b0, addr} < max_x - len_x) next_addr = addr + len_x[ASIZE-1:0];
    else                                   next_addr = start;
  endfunction

  assign done_fire = (state_q == S_BUSY) &&
                     ((mwr_q && mWR_DONE) || (mrd_q && mRD_DONE));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      logic [ASIZE-1:0] addr_q, max_q;
      logic [LSIZE-1:0] len_q;
      // Per-port write address/max/length: reload on LOAD, advance on own DONE.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          addr_q <= WR_ADDR[gi*ASIZE +: ASIZE];
          max_q  <= WR_MAX_ADDR[gi*ASIZE +: ASIZE];
          len_q  <= WR_LENGTH[gi*LSIZE +: LSIZE];
        end else if (WR_LOAD[gi]) begin
          addr_q <= WR_ADDR[gi*ASIZE +: ASIZE];
          max_q  <= WR_MAX_ADDR[gi*ASIZE +: ASIZE];
          len_q  <= WR_LENGTH[gi*LSIZE +: LSIZE];
        end else if (done_fire && mwr_q && wr_mask_q[gi]) begin
          addr_q <= next_addr(addr_q, max_q, len_q, WR_ADDR[gi*ASIZE +: ASIZE]);
        end
      end
      assign wr_addr_w[gi] = addr_q;
      assign wr_len_w[gi]  = len_q;
      assign wr_cand[gi]   = (len_q != '0) && (WR_RUSEDW[gi*LSIZE +: LSIZE] >= len_q);
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ASIZE-1:0] addr_q, max_q;
      logic [LSIZE-1:0] len_q;
      // Per-port read address/max/length: reload on LOAD, advance on own DONE.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          addr_q <= RD_ADDR[gi*ASIZE +: ASIZE];
          max_q  <= RD_MAX_ADDR[gi*ASIZE +: ASIZE];
          len_q  <= RD_LENGTH[gi*LSIZE +: LSIZE];
        end else if (RD_LOAD[gi]) begin
          addr_q <= RD_ADDR[gi*ASIZE +: ASIZE];
          max_q  <= RD_MAX_ADDR[gi*ASIZE +: ASIZE];
          len_q  <= RD_LENGTH[gi*LSIZE +: LSIZE];
        end else if (done_fire && mrd_q && rd_mask_q[gi]) begin
          addr_q <= next_addr(addr_q, max_q, len_q, RD_ADDR[gi*ASIZE +: ASIZE]);
        end
      end
      assign rd_addr_w[gi] = addr_q;
      assign rd_len_w[gi]  = len_q;
      assign rd_cand[gi]   = (len_q != '0) && (RD_WUSEDW[gi*LSIZE +: LSIZE] < len_q);
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  logic [WPW-1:0] wr_ptr_q;
  logic [RPW-1:0] rd_ptr_q;

  // Round-robin pick: scan from pointer+1 upward, wrapping; pointer itself last.
  always_comb begin
    logic [WPW:0] widx;
    logic [RPW:0] ridx;
    wr_any = 1'b0;
    wr_sel = '0;
    rd_any = 1'b0;
    rd_sel = '0;
    widx   = '0;
    ridx   = '0;
    for (int k = 1; k <= NUM_WR; k++) begin
      widx = {1'b0, wr_ptr_q} + (WPW+1)'(k);
      if (widx >= (WPW+1)'(NUM_WR)) widx = widx - (WPW+1)'(NUM_WR);
      if (!wr_any && wr_cand[widx[WPW-1:0]]) begin
        wr_any = 1'b1;
        wr_sel = widx[WPW-1:0];
      end
    end
    for (int k = 1; k <= NUM_RD; k++) begin
      ridx = {1'b0, rd_ptr_q} + (RPW+1)'(k);
      if (ridx >= (RPW+1)'(NUM_RD)) ridx = ridx - (RPW+1)'(NUM_RD);
      if (!rd_any && rd_cand[ridx[RPW-1:0]]) begin
        rd_any = 1'b1;
        rd_sel = ridx[RPW-1:0];
      end
    end
  end

  // Pointer remembers the last granted index of each class.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (grant_wr) wr_ptr_q <= wr_sel;
      if (grant_rd) rd_ptr_q <= rd_sel;
    end
  end
`else
  // Fixed priority: the lowest-index candidate of each class wins.
  always_comb begin
    wr_any = 1'b0;
    wr_sel = '0;
    rd_any = 1'b0;
    rd_sel = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (wr_cand[k]) begin
        wr_any = 1'b1;
        wr_sel = WPW'(k);
      end
    end
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      if (rd_cand[k]) begin
        rd_any = 1'b1;
        rd_sel = RPW'(k);
      end
    end
  end
`endif

  // Next-state logic: grant only from a quiet IDLE, release on matching DONE.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_q && CTRL_IDLE && !mwr_q && !mrd_q && !(|WR_LOAD) && !(|RD_LOAD)
            && (wr_any || rd_any)) begin
          state_d  = S_BUSY;
          grant_wr = wr_any;
          grant_rd = !wr_any;
        end
      end
      S_BUSY: begin
        if (done_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, post-reset settle flag and the registered grant outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      mwr_q     <= 1'b0;
      mrd_q     <= 1'b0;
      maddr_q   <= '0;
      mlen_q    <= '0;
      wr_mask_q <= '0;
      rd_mask_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (grant_wr) begin
        mwr_q     <= 1'b1;
        wr_mask_q <= NUM_WR'(1) << wr_sel;
        maddr_q   <= wr_addr_w[wr_sel];
        mlen_q    <= wr_len_w[wr_sel];
      end else if (grant_rd) begin
        mrd_q     <= 1'b1;
        rd_mask_q <= NUM_RD'(1) << rd_sel;
        maddr_q   <= rd_addr_w[rd_sel];
        mlen_q    <= rd_len_w[rd_sel];
      end else if (done_fire) begin
        mwr_q     <= 1'b0;
        mrd_q     <= 1'b0;
        wr_mask_q <= '0;
        rd_mask_q <= '0;
      end
    end
  end

  assign mWR     = mwr_q;
  assign mRD     = mrd_q;
  assign mADDR   = maddr_q;
  assign mLENGTH = mlen_q;
  assign WR_MASK = wr_mask_q;
  assign RD_MASK = rd_mask_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (2 write, 2 read ports). Expected
// values are hand-computed. Under ARB_ROUND_ROBIN_EN, the arbitration
// expectations switch to the round-robin order.
module tb_sdram_port_arbiter;
  localparam int NW = 2, NR = 2, AS = 23, LS = 9;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [NW-1:0]   WR_LOAD;
  logic [NW*AS-1:0] WR_ADDR, WR_MAX_ADDR;
  logic [NW*LS-1:0] WR_LENGTH, WR_RUSEDW;
  logic [NR-1:0]   RD_LOAD;
  logic [NR*AS-1:0] RD_ADDR, RD_MAX_ADDR;
  logic [NR*LS-1:0] RD_LENGTH, RD_WUSEDW;
  logic            CTRL_IDLE, mWR_DONE, mRD_DONE;
  logic            mWR, mRD;
  logic [AS-1:0]   mADDR;
  logic [LS-1:0]   mLENGTH;
  logic [NW-1:0]   WR_MASK;
  logic [NR-1:0]   RD_MASK;

  int n_checks = 0;
  int n_errors = 0;

  sdram_port_arbiter #(.NUM_WR(NW), .NUM_RD(NR), .ASIZE(AS), .LSIZE(LS)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_LOAD(WR_LOAD), .WR_ADDR(WR_ADDR), .WR_MAX_ADDR(WR_MAX_ADDR),
    .WR_LENGTH(WR_LENGTH), .WR_RUSEDW(WR_RUSEDW),
    .RD_LOAD(RD_LOAD), .RD_ADDR(RD_ADDR), .RD_MAX_ADDR(RD_MAX_ADDR),
    .RD_LENGTH(RD_LENGTH), .RD_WUSEDW(RD_WUSEDW),
    .CTRL_IDLE(CTRL_IDLE), .mWR_DONE(mWR_DONE), .mRD_DONE(mRD_DONE),
    .mWR(mWR), .mRD(mRD), .mADDR(mADDR), .mLENGTH(mLENGTH),
    .WR_MASK(WR_MASK), .RD_MASK(RD_MASK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_done(input string tag);
    mWR_DONE = 1'b1;
    step();
    mWR_DONE = 1'b0;
    chk({tag, "_mwr_low"}, 32'(mWR), 32'd0);
    chk({tag, "_mask_clr"}, 32'(WR_MASK), 32'd0);
  endtask

  logic [1:0]  exp_mask [4];
  logic [31:0] exp_addr [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_mask = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_addr = '{32'h2000, 32'h1100, 32'h2100, 32'h1200};
`else
    exp_mask = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_addr = '{32'h1100, 32'h1200, 32'h1300, 32'h1400};
`endif
    RESET_N   = 1'b0;
    WR_LOAD   = '0;
    RD_LOAD   = '0;
    CTRL_IDLE = 1'b0;
    mWR_DONE  = 1'b0;
    mRD_DONE  = 1'b0;
    WR_ADDR[0 +: AS]     = 23'h1000;
    WR_ADDR[AS +: AS]    = 23'h2000;
    WR_MAX_ADDR[0 +: AS] = 23'h40000;
    WR_MAX_ADDR[AS +: AS]= 23'h40000;
    WR_LENGTH[0 +: LS]   = 9'd256;
    WR_LENGTH[LS +: LS]  = 9'd256;
    WR_RUSEDW            = '0;
    RD_ADDR[0 +: AS]     = 23'h3000;
    RD_ADDR[AS +: AS]    = 23'h4000;
    RD_MAX_ADDR[0 +: AS] = 23'h40000;
    RD_MAX_ADDR[AS +: AS]= 23'h40000;
    RD_LENGTH[0 +: LS]   = 9'd128;
    RD_LENGTH[LS +: LS]  = 9'd0;
    RD_WUSEDW            = '0;

    // Reset state
    #1;
    chk("rst_mwr", 32'(mWR), 32'd0);
    chk("rst_mrd", 32'(mRD), 32'd0);
    chk("rst_maddr", 32'(mADDR), 32'd0);
    chk("rst_mlen", 32'(mLENGTH), 32'd0);
    chk("rst_wmask", 32'(WR_MASK), 32'd0);
    chk("rst_rmask", 32'(RD_MASK), 32'd0);
    step();
    step();
    RESET_N   = 1'b1;
    CTRL_IDLE = 1'b1;
    WR_RUSEDW[0 +: LS] = 9'd256;

    // First grant lands on the second edge after release; write beats read
    step();
    chk("first_edge_nogrant", 32'(mWR), 32'd0);
    step();
    chk("g1_mwr", 32'(mWR), 32'd1);
    chk("g1_mask", 32'(WR_MASK), 32'd1);
    chk("g1_addr", 32'(mADDR), 32'h1000);
    chk("g1_len", 32'(mLENGTH), 32'd256);
    chk("g1_mrd", 32'(mRD), 32'd0);
    step();
    step();
    chk("busy_hold_mwr", 32'(mWR), 32'd1);
    chk("busy_hold_addr", 32'(mADDR), 32'h1000);
    mRD_DONE = 1'b1;
    step();
    mRD_DONE = 1'b0;
    chk("wrong_done_ignored", 32'(mWR), 32'd1);
    wr_done("d1");
    step();
    chk("g2_addr_adv", 32'(mADDR), 32'h1100);
    wr_done("d2");

    // Load start 0x3FF00 then wrap back to the live input 0x1000
    WR_ADDR[0 +: AS] = 23'h3FF00;
    WR_LOAD = 2'b01;
    step();
    WR_LOAD = 2'b00;
    WR_ADDR[0 +: AS] = 23'h1000;
    chk("load_blocks_grant", 32'(mWR), 32'd0);
    step();
    chk("g3_addr_loaded", 32'(mADDR), 32'h3FF00);
    wr_done("d3");
    step();
    chk("g4_addr_wrap", 32'(mADDR), 32'h1000);

    // Both write ports and read port 0 candidates
    WR_RUSEDW[LS +: LS] = 9'd256;
    for (int k = 0; k < 4; k++) begin
      wr_done($sformatf("arb%0d", k));
      step();
      chk($sformatf("arb%0d_mask", k), 32'(WR_MASK), 32'(exp_mask[k]));
      chk($sformatf("arb%0d_addr", k), 32'(mADDR), exp_addr[k]);
      chk($sformatf("arb%0d_mrd", k), 32'(mRD), 32'd0);
    end

    // LOAD on port 1 during a port-0 grant
    WR_LOAD = 2'b10;
    WR_ADDR[AS +: AS] = 23'h5000;
    step();
    chk("load_no_abort_mwr", 32'(mWR), 32'd1);
    chk("load_no_abort_mask", 32'(WR_MASK), 32'd1);
    wr_done("dload");
    step();
    chk("load_hold_nogrant", 32'(mWR), 32'd0);
    WR_LOAD = 2'b00;
    step();
    chk("post_load_mwr", 32'(mWR), 32'd1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("post_load_mask", 32'(WR_MASK), 32'd2);
    chk("post_load_addr", 32'(mADDR), 32'h5000);
`else
    chk("post_load_mask", 32'(WR_MASK), 32'd1);
    chk("post_load_addr", 32'(mADDR), 32'h1500);
`endif

    // Read side: only read port 0 can be a candidate
    WR_RUSEDW = '0;
    wr_done("dlast");
    step();
    chk("rd_mrd", 32'(mRD), 32'd1);
    chk("rd_mask", 32'(RD_MASK), 32'd1);
    chk("rd_addr", 32'(mADDR), 32'h3000);
    chk("rd_len", 32'(mLENGTH), 32'd128);
    chk("rd_mwr", 32'(mWR), 32'd0);
    mWR_DONE = 1'b1;
    step();
    mWR_DONE = 1'b0;
    chk("rd_wrong_done", 32'(mRD), 32'd1);
    mRD_DONE = 1'b1;
    step();
    mRD_DONE = 1'b0;
    chk("rd_done_mrd", 32'(mRD), 32'd0);
    RD_WUSEDW[0 +: LS] = 9'd128;
    step();
    chk("rd_full_nogrant", 32'(mRD), 32'd0);
    step();
    chk("rd1_len0_never", 32'(RD_MASK), 32'd0);
    CTRL_IDLE = 1'b0;
    RD_WUSEDW[0 +: LS] = 9'd0;
    step();
    chk("ctrl_busy_nogrant", 32'(mRD), 32'd0);
    CTRL_IDLE = 1'b1;
    step();
    chk("rd2_mrd", 32'(mRD), 32'd1);
    chk("rd2_addr_adv", 32'(mADDR), 32'h3080);

    // Asynchronous reset in the middle of a grant
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_mrd", 32'(mRD), 32'd0);
    chk("async_rst_rmask", 32'(RD_MASK), 32'd0);
    chk("async_rst_addr", 32'(mADDR), 32'd0);
    chk("async_rst_len", 32'(mLENGTH), 32'd0);
    step();
    RESET_N = 1'b1;
    step();
    chk("rst2_first_edge", 32'(mRD), 32'd0);
    step();
    chk("rst2_mrd", 32'(mRD), 32'd1);
    chk("rst2_addr_reload", 32'(mADDR), 32'h3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
